// File: rtl/addseg7_pkg.sv
// Shared seven-segment constants for the addseg7 lab: active-low {g,f,e,d,c,b,a}
// patterns and the digit-index encoding used by the scanner.
package addseg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_O     = 7'b0100011;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    // Digit index equals the bit position of its anode; DIG_3 is the leftmost digit.
    typedef enum logic [1:0] {
        DIG_0 = 2'd0,
        DIG_1 = 2'd1,
        DIG_2 = 2'd2,
        DIG_3 = 2'd3
    } digit_e;

    localparam digit_e DIG_FIRST = DIG_3;

    function automatic digit_e digit_next(input digit_e d);
        return (d == DIG_0) ? DIG_3 : digit_e'(d - 2'd1);
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational 4-bit value to active-low seven-segment decoder.
// Values above 9 decode to a blank digit.
module seg7_dec
    import addseg7_pkg::*;
(
    input  logic [3:0] i_value,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_value <= 4'd9) begin
            o_seg = SEG_DIGIT[i_value];
        end
    end

endmodule

// File: rtl/addsub_disp_scan.sv
// Captures a signed 4-bit add/sub result plus overflow flag and scans it as
// sign + magnitude onto a 4-digit common-anode display, blinking "o" on overflow.
module addsub_disp_scan
    import addseg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] sum,
    input  logic       ov,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_DIV - 1);

    logic signed [3:0]    r_sum;
    logic                 r_ov;
    logic [SLOT_W-1:0]    r_slot;
    digit_e               r_idx;
    logic [FRAME_W-1:0]   r_frame;
    logic                 r_blink;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;

    logic signed [3:0]    w_sum_nxt;
    logic                 w_ov_nxt;
    logic signed [4:0]    w_sum_ext;
    logic [4:0]           w_mag;
    logic                 w_neg;
    logic [3:0]           w_dec_in;
    logic [6:0]           w_dec_seg;

    logic                 w_slot_wrap;
    logic                 w_frame_tick;
    logic [SLOT_W-1:0]    w_slot_nxt;
    digit_e               w_idx_nxt;
    logic [FRAME_W-1:0]   w_frame_nxt;
    logic                 w_blink_nxt;
    logic [3:0]           w_an_nxt;
    logic [6:0]           w_seg_nxt;

    // Outputs are registered from next-state values so a capture at edge N
    // and the slot position after edge N appear together in cycle N+1.
    assign w_sum_nxt = in_valid ? signed'(sum) : r_sum;
    assign w_ov_nxt  = in_valid ? ov : r_ov;

    // Five bits wide so that -8 negates to +8 instead of wrapping.
    assign w_sum_ext = {w_sum_nxt[3], w_sum_nxt};
    assign w_neg     = w_sum_nxt[3];
    assign w_mag     = w_neg ? $unsigned(-w_sum_ext) : $unsigned(w_sum_ext);
    assign w_dec_in  = (w_mag > 5'd9) ? 4'hF : w_mag[3:0];

    seg7_dec u_dec (
        .i_value (w_dec_in),
        .o_seg   (w_dec_seg)
    );

    always_comb begin
        w_slot_wrap  = (r_slot == SLOT_LAST);
        w_frame_tick = w_slot_wrap && (r_idx == DIG_0);
        w_slot_nxt   = w_slot_wrap ? '0 : r_slot + SLOT_W'(1);
        w_idx_nxt    = w_slot_wrap ? digit_next(r_idx) : r_idx;
        w_frame_nxt  = r_frame;
        w_blink_nxt  = r_blink;
        if (w_frame_tick) begin
            if (r_frame == FRAME_LAST) begin
                w_frame_nxt = '0;
                w_blink_nxt = ~r_blink;
            end else begin
                w_frame_nxt = r_frame + FRAME_W'(1);
            end
        end
    end

    // Slot cycle 0 stays dark so the previous digit's segments never ghost
    // onto the next anode while the drivers switch.
    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = SEG_BLANK;
        if (w_slot_nxt != '0) begin
            case (w_idx_nxt)
                DIG_3: begin
                    w_an_nxt  = 4'b0111;
                    w_seg_nxt = w_neg ? SEG_MINUS : SEG_BLANK;
                end
                DIG_2: begin
                    w_an_nxt  = 4'b1011;
                    w_seg_nxt = w_dec_seg;
                end
                DIG_1: begin
                    w_an_nxt  = 4'b1101;
                end
                DIG_0: begin
                    w_an_nxt  = 4'b1110;
                    w_seg_nxt = (w_ov_nxt && w_blink_nxt) ? SEG_O : SEG_BLANK;
                end
                default: begin
                    w_an_nxt  = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_ov    <= 1'b0;
            r_slot  <= '0;
            r_idx   <= DIG_FIRST;
            r_frame <= '0;
            r_blink <= 1'b1;
            r_an    <= 4'b1111;
            r_seg   <= SEG_BLANK;
        end else begin
            r_sum   <= w_sum_nxt;
            r_ov    <= w_ov_nxt;
            r_slot  <= w_slot_nxt;
            r_idx   <= w_idx_nxt;
            r_frame <= w_frame_nxt;
            r_blink <= w_blink_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_addsub_disp_scan.sv
// Directed bench for addsub_disp_scan with SCAN_DIV = 4 and BLINK_DIV = 2.
// cyc counts rising edges since reset release; cycle c sits in slot c%4 of digit 3-(c/4)%4.
module tb_addsub_disp_scan;

    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] LET_O = 7'b0100011;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] sum;
    logic       ov;
    logic [3:0] an;
    logic [6:0] seg;

    int total;
    int bad;
    int cyc;

    addsub_disp_scan #(
        .SCAN_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .sum      (sum),
        .ov       (ov),
        .an       (an),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int dig_of(int c);
        return 3 - ((c / 4) % 4);
    endfunction

    function automatic logic [3:0] exp_an(int c);
        if (c % 4 == 0) return 4'b1111;
        case (dig_of(c))
            3: return 4'b0111;
            2: return 4'b1011;
            1: return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(int c, logic [6:0] s3, logic [6:0] s2, logic [6:0] s0);
        if (c % 4 == 0) return BLANK;
        case (dig_of(c))
            3: return s3;
            2: return s2;
            1: return BLANK;
            default: return s0;
        endcase
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sum      = 4'b0000;
        ov       = 1'b0;
        cyc      = 0;
        repeat (3) step();
        total++;
        if (an !== 4'b1111) begin
            bad++;
            $display("FAIL reset_an got=%b want=1111", an);
        end
        total++;
        if (seg !== BLANK) begin
            bad++;
            $display("FAIL reset_seg got=%b want=%b", seg, BLANK);
        end
        rst_n = 1'b1;
        cyc   = 0;
        total++;
        if (an !== 4'b1111 || seg !== BLANK) begin
            bad++;
            $display("FAIL release_idle got an=%b seg=%b want an=1111 seg=%b", an, seg, BLANK);
        end
    endtask

    task automatic test_idle_frames();
        for (int i = 0; i < 32; i++) begin
            step();
            total++;
            if (an !== exp_an(cyc)) begin
                bad++;
                $display("FAIL idle_an cyc=%0d got=%b want=%b", cyc, an, exp_an(cyc));
            end
            total++;
            if (seg !== exp_seg(cyc, BLANK, 7'b1000000, BLANK)) begin
                bad++;
                $display("FAIL idle_seg cyc=%0d got=%b want=%b", cyc, seg,
                         exp_seg(cyc, BLANK, 7'b1000000, BLANK));
            end
        end
    endtask

    task automatic test_neg3();
        in_valid = 1'b1;
        sum      = 4'b1101;
        ov       = 1'b0;
        step();
        in_valid = 1'b0;
        sum      = 4'b0111;
        ov       = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i != 0) step();
            total++;
            if (an !== exp_an(cyc)) begin
                bad++;
                $display("FAIL neg3_an cyc=%0d got=%b want=%b", cyc, an, exp_an(cyc));
            end
            total++;
            if (seg !== exp_seg(cyc, MINUS, 7'b0110000, BLANK)) begin
                bad++;
                $display("FAIL neg3_seg cyc=%0d got=%b want=%b", cyc, seg,
                         exp_seg(cyc, MINUS, 7'b0110000, BLANK));
            end
        end
        ov = 1'b0;
    endtask

    task automatic test_ov_blink();
        logic [6:0] s0;
        in_valid = 1'b1;
        sum      = 4'b1000;
        ov       = 1'b1;
        step();
        in_valid = 1'b0;
        sum      = 4'b0000;
        ov       = 1'b0;
        for (int i = 0; i < 81; i++) begin
            if (i != 0) step();
            s0 = (((cyc / 32) % 2) == 0) ? LET_O : BLANK;
            total++;
            if (an !== exp_an(cyc)) begin
                bad++;
                $display("FAIL blink_an cyc=%0d got=%b want=%b", cyc, an, exp_an(cyc));
            end
            total++;
            if (seg !== exp_seg(cyc, MINUS, 7'b0000000, s0)) begin
                bad++;
                $display("FAIL blink_seg cyc=%0d got=%b want=%b", cyc, seg,
                         exp_seg(cyc, MINUS, 7'b0000000, s0));
            end
        end
    endtask

    task automatic test_mid_slot_capture();
        int guard;
        guard = 0;
        while (cyc % 16 != 6 && guard < 16) begin
            step();
            guard++;
        end
        total++;
        if (cyc % 16 != 6) begin
            bad++;
            $display("FAIL midcap_align got=%0d want=6", cyc % 16);
        end
        total++;
        if (an !== 4'b1011 || seg !== 7'b0000000) begin
            bad++;
            $display("FAIL midcap_before got an=%b seg=%b want an=1011 seg=0000000", an, seg);
        end
        in_valid = 1'b1;
        sum      = 4'b0101;
        ov       = 1'b0;
        step();
        in_valid = 1'b0;
        sum      = 4'b0000;
        total++;
        if (an !== 4'b1011 || seg !== 7'b0010010) begin
            bad++;
            $display("FAIL midcap_after got an=%b seg=%b want an=1011 seg=0010010", an, seg);
        end
        step();
        total++;
        if (an !== 4'b1111 || seg !== BLANK) begin
            bad++;
            $display("FAIL midcap_slot_end got an=%b seg=%b want an=1111 seg=%b", an, seg, BLANK);
        end
        step();
        total++;
        if (an !== 4'b1101 || seg !== BLANK) begin
            bad++;
            $display("FAIL midcap_d1 got an=%b seg=%b want an=1101 seg=%b", an, seg, BLANK);
        end
    endtask

    task automatic test_async_reset();
        int guard;
        in_valid = 1'b1;
        sum      = 4'b1000;
        ov       = 1'b1;
        step();
        in_valid = 1'b0;
        ov       = 1'b0;
        guard    = 0;
        while (!((cyc % 16) >= 13 && ((cyc / 32) % 2) == 0) && guard < 64) begin
            step();
            guard++;
        end
        total++;
        if (an !== 4'b1110 || seg !== LET_O) begin
            bad++;
            $display("FAIL arst_pre got an=%b seg=%b want an=1110 seg=%b", an, seg, LET_O);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (an !== 4'b1111) begin
            bad++;
            $display("FAIL arst_an got=%b want=1111", an);
        end
        total++;
        if (seg !== BLANK) begin
            bad++;
            $display("FAIL arst_seg got=%b want=%b", seg, BLANK);
        end
        step();
        step();
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (an !== exp_an(cyc) || seg !== exp_seg(cyc, BLANK, 7'b1000000, BLANK)) begin
                bad++;
                $display("FAIL arst_after cyc=%0d got an=%b seg=%b want an=%b seg=%b", cyc, an, seg,
                         exp_an(cyc), exp_seg(cyc, BLANK, 7'b1000000, BLANK));
            end
        end
    endtask

    task automatic test_sweep();
        logic [6:0] exp3 [16];
        logic [6:0] exp2 [16];
        logic [6:0] last3;
        logic [3:0] v;
        int guard;
        exp3 = '{MINUS, MINUS, MINUS, MINUS, MINUS, MINUS, MINUS, MINUS,
                 BLANK, BLANK, BLANK, BLANK, BLANK, BLANK, BLANK, BLANK};
        exp2 = '{7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
                 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001,
                 7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
        last3 = BLANK;
        guard = 0;
        while (cyc % 16 != 0 && guard < 16) begin
            step();
            guard++;
        end
        in_valid = 1'b1;
        ov       = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v   = 4'(i);
            sum = v ^ 4'b1000;
            for (int k = 0; k < 16; k++) begin
                step();
                total++;
                if (an !== exp_an(cyc) || seg !== exp_seg(cyc, exp3[i], exp2[i], BLANK)) begin
                    bad++;
                    $display("FAIL sweep sum=%b cyc=%0d got an=%b seg=%b want an=%b seg=%b", sum, cyc,
                             an, seg, exp_an(cyc), exp_seg(cyc, exp3[i], exp2[i], BLANK));
                end
                total++;
                if ($countones(~an) > 1) begin
                    bad++;
                    $display("FAIL sweep_onehot cyc=%0d got an=%b want at most one low", cyc, an);
                end
                if (an == 4'b0111) last3 = seg;
                if (an == 4'b1011 && seg == 7'b1000000) begin
                    total++;
                    if (last3 !== BLANK) begin
                        bad++;
                        $display("FAIL sweep_minus_zero cyc=%0d got d3=%b want %b", cyc, last3, BLANK);
                    end
                end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_idle_frames();
        test_neg3();
        test_ov_blink();
        test_mid_slot_capture();
        test_async_reset();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_disp_scan.md
Name: addsub_disp_scan

Overview:
- Display end of the 4-bit signed add/sub datapath.
- Captures a 4-bit two's-complement result and its overflow flag on an input strobe.
- Converts the captured result to sign + magnitude and time-multiplexes it onto a 4-digit common-anode seven-segment display.
- Sits between the add/sub unit and the board display pins in the addseg7 top level.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot (minimum 2).
- BLINK_DIV, 64, full 4-digit frames per half-period of the overflow blink (minimum 1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  capture strobe; sum/ov are sampled on any rising clk edge where it is high.
- sum  input  4  signed two's-complement result from add/sub.
- ov  input  1  signed overflow flag from add/sub.
- an  output  4  digit enables, active-low; an[3] is the leftmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- While rst_n = 0:
  - an = 4'b1111, seg = 7'h7F.
  - Captured sum and ov = 0.
  - Slot counter = 0, digit index = 3, frame counter = 0, blink phase = 1 (visible).
  - Reset asserted mid-slot or mid-frame clears everything immediately.
- Capture: in_valid is sampled every cycle; there is no backpressure. The value seen at edge N drives the segments from cycle N+1. A capture never restarts the slot or frame. If in_valid is held high, the display tracks the inputs each cycle.
- Conversion: magnitude = sum[3] ? -sum : sum, computed 5 bits wide so that -8 gives 8; negative = sum[3]. Digit contents:
  - d3: SEG_MINUS if negative, else blank.
  - d2: magnitude digit 0..8.
  - d1: blank.
  - d0: SEG_O if captured ov = 1 and blink phase = 1, else blank.
- Scan:
  - Slot counter runs 0..SCAN_DIV-1 and wraps.
  - At wrap, digit index decrements 3→2→1→0→3.
  - Slot cycle 0 is the anti-ghost blank cycle: an = 4'b1111, seg = 7'h7F.
  - Slot cycles 1..SCAN_DIV-1: an has a single 0 at the digit-index bit, and seg carries that digit's pattern.
  - an and seg are registered. The first driven cycle after reset release is cycle 1 of slot d3.
- Blink:
  - The frame counter increments when digit index goes 0→3.
  - When the frame counter reaches BLINK_DIV-1 and wraps, blink phase toggles.
  - Blink affects only d0, and only when ov = 1. With ov = 0, d0 is always blank.
- Boundary cases:
  - sum = 4'b1000 shows "-8".
  - sum = 0 shows blank and "0"; there is never a "-0".
  - Overflow is displayed only as flagged; the result is shown as captured, with no correction.

Decomposition:
- Shared package addseg7_pkg holds the segment constants (active-low gfedcba):
  - SEG_BLANK 7'h7F, SEG_MINUS 7'b0111111, SEG_O 7'b0100011.
  - SEG_DIGIT[0..9] table, e.g. 0 = 7'b1000000, 3 = 7'b0110000, 5 = 7'b0010010, 8 = 7'b0000000.
  - Digit-index encoding.
- One sub-module, seg7_dec: a combinational 4-bit value → 7-segment pattern decoder using the package table. It is shared with other labs.
- Top-level logic: capture registers, sign/magnitude, slot/frame/blink counters, output registers.

Test Plan (SCAN_DIV = 4, BLINK_DIV = 2):
- Reset, then release with no capture → cycle 0 of each slot gives an = 1111. Driven cycles give d3 blank, d2 = 7'b1000000 with an = 1011, d1 blank, d0 blank. The 16-cycle frame repeats.
- in_valid pulse with sum = 4'b1101 (-3), ov = 0 → during d3 slot, an = 0111 and seg = 7'b0111111. During d2 slot, an = 1011 and seg = 7'b0110000. d0 stays blank.
- sum = 4'b1000, ov = 1 → d3 shows minus, d2 = 7'b0000000, d0 = 7'b0100011 for 2 frames, then blank for 2 frames, alternating.
- Capture sum = 4'b0101 on cycle 2 of the d2 slot → d2 pattern changes to 7'b0010010 on the next cycle, with no slot restart and the slot still ending at cycle 3.
- Assert rst_n low mid-slot with ov displayed → an = 1111 and seg = 7'h7F in the same cycle, without waiting for a clock edge. After release, the display shows blank and "0".
- Hold in_valid high while sweeping sum from -8 to 7 once per frame → d3/d2 patterns match the sign/magnitude table for every value. The bench checks there is never a minus with 0 and never more than one an bit low.
